// File: rtl/ss_prf_pkg.sv
// Shared constants and types for the superscalar physical register file.
package ss_prf_pkg;

    localparam int WIDTH   = 2;
    localparam int RF_SIZE = 64;
    localparam int XLEN    = 32;
    localparam int IDX_W   = $clog2(RF_SIZE);

    typedef logic [IDX_W-1:0] prf_idx_t;
    typedef logic [XLEN-1:0]  prf_data_t;

endpackage

// File: rtl/ss_prf_bypass.sv
// Per-read-port result select: register 0 is hardwired, otherwise the
// highest-numbered matching write port forwards its data ahead of storage.
module ss_prf_bypass
    import ss_prf_pkg::*;
#(
    parameter int WIDTH = ss_prf_pkg::WIDTH,
    parameter int XLEN  = ss_prf_pkg::XLEN,
    parameter int IDX_W = ss_prf_pkg::IDX_W
) (
    input  logic                        reset_i,
    input  logic [IDX_W-1:0]            rd_idx_i,
    input  logic [WIDTH-1:0]            wr_en_i,
    input  logic [WIDTH-1:0][IDX_W-1:0] wr_idx_i,
    input  logic [WIDTH-1:0][XLEN-1:0]  wr_data_i,
    input  logic [XLEN-1:0]             st_data_i,
    input  logic                        st_rdy_i,
    output logic [XLEN-1:0]             rd_data_o,
    output logic                        rd_rdy_o
);

    // Ascending scan so the highest-numbered matching port is the last to assign.
    always_comb begin
        rd_data_o = st_data_i;
        rd_rdy_o  = st_rdy_i;
        if (rd_idx_i == '0) begin
            rd_data_o = '0;
            rd_rdy_o  = 1'b1;
        end else if (!reset_i) begin
            for (int w = 0; w < WIDTH; w++) begin
                if (wr_en_i[w] && (wr_idx_i[w] == rd_idx_i)) begin
                    rd_data_o = wr_data_i[w];
                    rd_rdy_o  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ss_prf.sv
// Superscalar physical register file: WIDTH write ports, WIDTH ready-bit
// clear ports, 2*WIDTH combinational read ports with same-cycle write bypass.
module ss_prf
    import ss_prf_pkg::*;
#(
    parameter  int WIDTH   = ss_prf_pkg::WIDTH,
    parameter  int RF_SIZE = ss_prf_pkg::RF_SIZE,
    parameter  int XLEN    = ss_prf_pkg::XLEN,
    localparam int NRD     = 2 * WIDTH,
    localparam int IDX_W   = $clog2(RF_SIZE)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NRD-1:0][IDX_W-1:0]   rd_idx,
    output logic [NRD-1:0][XLEN-1:0]    rd_data,
    output logic [NRD-1:0]              rd_rdy,
    input  logic [WIDTH-1:0]            wr_en,
    input  logic [WIDTH-1:0][IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0][XLEN-1:0]  wr_data,
    input  logic [WIDTH-1:0]            clr_en,
    input  logic [WIDTH-1:0][IDX_W-1:0] clr_idx
);

    logic [RF_SIZE-1:0][XLEN-1:0] data_q, data_d;
    logic [RF_SIZE-1:0]           rdy_q,  rdy_d;

    // Next state: writes in ascending port order (last wins), then clears so
    // a clear overrides a same-cycle write's ready bit but leaves its data.
    always_comb begin
        data_d = data_q;
        rdy_d  = rdy_q;
        for (int w = 0; w < WIDTH; w++) begin
            if (wr_en[w] && (wr_idx[w] != '0)) begin
                data_d[wr_idx[w]] = wr_data[w];
                rdy_d[wr_idx[w]]  = 1'b1;
            end
        end
        for (int c = 0; c < WIDTH; c++) begin
            if (clr_en[c] && (clr_idx[c] != '0)) begin
                rdy_d[clr_idx[c]] = 1'b0;
            end
        end
    end

    // Single state register; reset wipes data and marks every entry ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
            rdy_q  <= '1;
        end else begin
            data_q <= data_d;
            rdy_q  <= rdy_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        ss_prf_bypass #(
            .WIDTH (WIDTH),
            .XLEN  (XLEN),
            .IDX_W (IDX_W)
        ) u_bypass (
            .reset_i   (reset),
            .rd_idx_i  (rd_idx[p]),
            .wr_en_i   (wr_en),
            .wr_idx_i  (wr_idx),
            .wr_data_i (wr_data),
            .st_data_i (data_q[rd_idx[p]]),
            .st_rdy_i  (rdy_q[rd_idx[p]]),
            .rd_data_o (rd_data[p]),
            .rd_rdy_o  (rd_rdy[p])
        );
    end

endmodule

// File: tb/tb_ss_prf.sv
// Directed bench for ss_prf with a reference register-file model.
module tb_ss_prf;

    localparam int W   = 2;
    localparam int NR  = 2 * W;
    localparam int N   = 64;
    localparam int XL  = 32;
    localparam int IW  = 6;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NR-1:0][IW-1:0]    rd_idx;
    logic [NR-1:0][XL-1:0]    rd_data;
    logic [NR-1:0]            rd_rdy;
    logic [W-1:0]             wr_en;
    logic [W-1:0][IW-1:0]     wr_idx;
    logic [W-1:0][XL-1:0]     wr_data;
    logic [W-1:0]             clr_en;
    logic [W-1:0][IW-1:0]     clr_idx;

    int errors = 0;
    int checks = 0;

    ss_prf dut (
        .clock   (clock),
        .reset   (reset),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .rd_rdy  (rd_rdy),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .clr_en  (clr_en),
        .clr_idx (clr_idx)
    );

    always #5 clock = ~clock;

    // Reference model: plain arrays holding the architectural contents.
    logic [XL-1:0] mdata [N];
    bit            mrdy  [N];
    bit            model_ok = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mdata[i] <= '0;
                mrdy[i]  <= 1'b1;
            end
            model_ok <= 1'b1;
        end else if (model_ok) begin
            for (int w = 0; w < W; w++)
                if (wr_en[w] && wr_idx[w] != 0) begin
                    mdata[wr_idx[w]] <= wr_data[w];
                    mrdy[wr_idx[w]]  <= 1'b1;
                end
            for (int c = 0; c < W; c++)
                if (clr_en[c] && clr_idx[c] != 0)
                    mrdy[clr_idx[c]] <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [XL-1:0] act, input logic [XL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Compare process: every read port against the model on every cycle.
    always @(negedge clock) begin
        if (model_ok) begin
            for (int p = 0; p < NR; p++) begin
                logic [XL-1:0] ed;
                logic          er;
                bit            hit;
                hit = 1'b0;
                if (rd_idx[p] == 0) begin
                    ed = '0; er = 1'b1;
                end else begin
                    ed = mdata[rd_idx[p]]; er = mrdy[rd_idx[p]];
                    if (!reset)
                        for (int w = W - 1; w >= 0; w--)
                            if (!hit && wr_en[w] && wr_idx[w] == rd_idx[p]) begin
                                ed = wr_data[w]; er = 1'b1; hit = 1'b1;
                            end
                end
                chk($sformatf("model_data[%0d]", p), rd_data[p], ed);
                chk($sformatf("model_rdy[%0d]", p), {31'd0, rd_rdy[p]}, {31'd0, er});
            end
        end
    end

    task automatic idle();
        wr_en = '0; wr_idx = '0; wr_data = '0;
        clr_en = '0; clr_idx = '0;
    endtask

    // Advance to the next cycle's drive point.
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        rd_idx = '0;
        idle();
        next(); next();
        reset = 1'b0;

        // Post-reset contents
        rd_idx = {6'd63, 6'd5, 6'd63, 6'd5};
        sample();
        chk("rst_data5",  rd_data[0], 32'h0);
        chk("rst_rdy5",   {31'd0, rd_rdy[0]}, 32'd1);
        chk("rst_data63", rd_data[1], 32'h0);
        chk("rst_rdy63",  {31'd0, rd_rdy[1]}, 32'd1);

        // Port0 writes idx7, port1 targets idx0
        next();
        wr_en = 2'b11;
        wr_idx = {6'd0, 6'd7};
        wr_data = {32'hAAAA_AAAA, 32'h1234_5678};
        rd_idx = {6'd0, 6'd7, 6'd0, 6'd7};
        sample();
        chk("byp_idx7", rd_data[0], 32'h1234_5678);
        chk("byp_idx0", rd_data[1], 32'h0);
        next(); idle();
        sample();
        chk("st_idx7", rd_data[0], 32'h1234_5678);
        chk("st_idx0", rd_data[1], 32'h0);

        // Both ports write idx9: port1 wins
        next();
        wr_en = 2'b11;
        wr_idx = {6'd9, 6'd9};
        wr_data = {32'h2222_2222, 32'h1111_1111};
        rd_idx = {6'd9, 6'd9, 6'd9, 6'd9};
        sample();
        chk("byp_idx9", rd_data[0], 32'h2222_2222);
        next(); idle();
        sample();
        chk("st_idx9", rd_data[0], 32'h2222_2222);

        // Clear idx12; same-cycle read still ready
        next();
        clr_en = 2'b01; clr_idx = {6'd0, 6'd12};
        rd_idx = {6'd12, 6'd12, 6'd12, 6'd12};
        sample();
        chk("clr_same_rdy", {31'd0, rd_rdy[0]}, 32'd1);
        next(); idle();
        sample();
        chk("clr_next_rdy",  {31'd0, rd_rdy[0]}, 32'd0);
        chk("clr_next_data", rd_data[0], 32'h0);
        next();
        wr_en = 2'b10; wr_idx = {6'd12, 6'd0}; wr_data = {32'hDEAD_BEEF, 32'h0};
        sample();
        chk("wr12_byp_rdy",  {31'd0, rd_rdy[0]}, 32'd1);
        chk("wr12_byp_data", rd_data[0], 32'hDEAD_BEEF);

        // Write and clear idx20 together: data lands, ready ends low
        next(); idle();
        wr_en = 2'b01; wr_idx = {6'd0, 6'd20}; wr_data = {32'h0, 32'hCAFE_0001};
        clr_en = 2'b10; clr_idx = {6'd20, 6'd0};
        rd_idx = {6'd20, 6'd20, 6'd20, 6'd20};
        next(); idle();
        sample();
        chk("wc20_data", rd_data[0], 32'hCAFE_0001);
        chk("wc20_rdy",  {31'd0, rd_rdy[0]}, 32'd0);

        // Write idx0 with clear idx0: register 0 unaffected
        next();
        wr_en = 2'b01; wr_idx = {6'd0, 6'd0}; wr_data = {32'h0, 32'h5555_5555};
        clr_en = 2'b01; clr_idx = {6'd0, 6'd0};
        rd_idx = {6'd0, 6'd0, 6'd0, 6'd0};
        next(); idle();
        sample();
        chk("z_data", rd_data[2], 32'h0);
        chk("z_rdy",  {31'd0, rd_rdy[2]}, 32'd1);

        // Write idx30=5, then reset while writing 9 there
        next();
        wr_en = 2'b01; wr_idx = {6'd0, 6'd30}; wr_data = {32'h0, 32'h5};
        rd_idx = {6'd20, 6'd30, 6'd20, 6'd30};
        next();
        reset = 1'b1;
        wr_data = {32'h0, 32'h9};
        sample();
        chk("rstw_nobyp", rd_data[0], 32'h5);
        next();
        reset = 1'b0; idle();
        sample();
        chk("rstw_data30", rd_data[0], 32'h0);
        chk("rstw_rdy30",  {31'd0, rd_rdy[0]}, 32'd1);
        chk("rstw_rdy20",  {31'd0, rd_rdy[1]}, 32'd1);

        // Mixed traffic over a small index window, checked by the model
        for (int k = 0; k < 60; k++) begin
            next();
            wr_en = W'($urandom_range(0, 3));
            clr_en = W'($urandom_range(0, 3));
            for (int w = 0; w < W; w++) begin
                wr_idx[w]  = IW'($urandom_range(0, 7));
                wr_data[w] = $urandom;
                clr_idx[w] = IW'($urandom_range(0, 7));
            end
            for (int p = 0; p < NR; p++) rd_idx[p] = IW'($urandom_range(0, 7));
        end
        next(); idle();
        sample();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
